inv_sub_bytes_iter: RTL and testbench

Iterative AES InvSubBytes stage for the decryption datapath. Consumes the 128-bit state produced by the inverse row-shift stage and applies the inverse S-box to all 16 bytes. The default build time-shares four inverse S-box lookups across four cycles, one column per cycle. Valid/ready handshakes on both sides let it sit between registered round stages and absorb backpressure from the downstream AddRoundKey stage.

---
 rtl/inv_sub_bytes_iter.sv | 225 ++++++++++++++++++++++
 tb/tb_inv_sub_bytes_iter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_iter.sv
// AES InvSubBytes stage with valid/ready handshakes: one column per cycle through four inverse S-boxes.
// Define INV_SUB_BYTES_FAST_EN for a single-cycle build with sixteen parallel inverse S-boxes.
module inv_sub_bytes_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [127:0] i_in_state,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [127:0] o_out_state
);

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] r;
        case (b)
            8'h00: r = 8'h52;  8'h01: r = 8'h09;  8'h02: r = 8'h6a;  8'h03: r = 8'hd5;
            8'h04: r = 8'h30;  8'h05: r = 8'h36;  8'h06: r = 8'ha5;  8'h07: r = 8'h38;
            8'h08: r = 8'hbf;  8'h09: r = 8'h40;  8'h0a: r = 8'ha3;  8'h0b: r = 8'h9e;
            8'h0c: r = 8'h81;  8'h0d: r = 8'hf3;  8'h0e: r = 8'hd7;  8'h0f: r = 8'hfb;
            8'h10: r = 8'h7c;  8'h11: r = 8'he3;  8'h12: r = 8'h39;  8'h13: r = 8'h82;
            8'h14: r = 8'h9b;  8'h15: r = 8'h2f;  8'h16: r = 8'hff;  8'h17: r = 8'h87;
            8'h18: r = 8'h34;  8'h19: r = 8'h8e;  8'h1a: r = 8'h43;  8'h1b: r = 8'h44;
            8'h1c: r = 8'hc4;  8'h1d: r = 8'hde;  8'h1e: r = 8'he9;  8'h1f: r = 8'hcb;
            8'h20: r = 8'h54;  8'h21: r = 8'h7b;  8'h22: r = 8'h94;  8'h23: r = 8'h32;
            8'h24: r = 8'ha6;  8'h25: r = 8'hc2;  8'h26: r = 8'h23;  8'h27: r = 8'h3d;
            8'h28: r = 8'hee;  8'h29: r = 8'h4c;  8'h2a: r = 8'h95;  8'h2b: r = 8'h0b;
            8'h2c: r = 8'h42;  8'h2d: r = 8'hfa;  8'h2e: r = 8'hc3;  8'h2f: r = 8'h4e;
            8'h30: r = 8'h08;  8'h31: r = 8'h2e;  8'h32: r = 8'ha1;  8'h33: r = 8'h66;
            8'h34: r = 8'h28;  8'h35: r = 8'hd9;  8'h36: r = 8'h24;  8'h37: r = 8'hb2;
            8'h38: r = 8'h76;  8'h39: r = 8'h5b;  8'h3a: r = 8'ha2;  8'h3b: r = 8'h49;
            8'h3c: r = 8'h6d;  8'h3d: r = 8'h8b;  8'h3e: r = 8'hd1;  8'h3f: r = 8'h25;
            8'h40: r = 8'h72;  8'h41: r = 8'hf8;  8'h42: r = 8'hf6;  8'h43: r = 8'h64;
            8'h44: r = 8'h86;  8'h45: r = 8'h68;  8'h46: r = 8'h98;  8'h47: r = 8'h16;
            8'h48: r = 8'hd4;  8'h49: r = 8'ha4;  8'h4a: r = 8'h5c;  8'h4b: r = 8'hcc;
            8'h4c: r = 8'h5d;  8'h4d: r = 8'h65;  8'h4e: r = 8'hb6;  8'h4f: r = 8'h92;
            8'h50: r = 8'h6c;  8'h51: r = 8'h70;  8'h52: r = 8'h48;  8'h53: r = 8'h50;
            8'h54: r = 8'hfd;  8'h55: r = 8'hed;  8'h56: r = 8'hb9;  8'h57: r = 8'hda;
            8'h58: r = 8'h5e;  8'h59: r = 8'h15;  8'h5a: r = 8'h46;  8'h5b: r = 8'h57;
            8'h5c: r = 8'ha7;  8'h5d: r = 8'h8d;  8'h5e: r = 8'h9d;  8'h5f: r = 8'h84;
            8'h60: r = 8'h90;  8'h61: r = 8'hd8;  8'h62: r = 8'hab;  8'h63: r = 8'h00;
            8'h64: r = 8'h8c;  8'h65: r = 8'hbc;  8'h66: r = 8'hd3;  8'h67: r = 8'h0a;
            8'h68: r = 8'hf7;  8'h69: r = 8'he4;  8'h6a: r = 8'h58;  8'h6b: r = 8'h05;
            8'h6c: r = 8'hb8;  8'h6d: r = 8'hb3;  8'h6e: r = 8'h45;  8'h6f: r = 8'h06;
            8'h70: r = 8'hd0;  8'h71: r = 8'h2c;  8'h72: r = 8'h1e;  8'h73: r = 8'h8f;
            8'h74: r = 8'hca;  8'h75: r = 8'h3f;  8'h76: r = 8'h0f;  8'h77: r = 8'h02;
            8'h78: r = 8'hc1;  8'h79: r = 8'haf;  8'h7a: r = 8'hbd;  8'h7b: r = 8'h03;
            8'h7c: r = 8'h01;  8'h7d: r = 8'h13;  8'h7e: r = 8'h8a;  8'h7f: r = 8'h6b;
            8'h80: r = 8'h3a;  8'h81: r = 8'h91;  8'h82: r = 8'h11;  8'h83: r = 8'h41;
            8'h84: r = 8'h4f;  8'h85: r = 8'h67;  8'h86: r = 8'hdc;  8'h87: r = 8'hea;
            8'h88: r = 8'h97;  8'h89: r = 8'hf2;  8'h8a: r = 8'hcf;  8'h8b: r = 8'hce;
            8'h8c: r = 8'hf0;  8'h8d: r = 8'hb4;  8'h8e: r = 8'he6;  8'h8f: r = 8'h73;
            8'h90: r = 8'h96;  8'h91: r = 8'hac;  8'h92: r = 8'h74;  8'h93: r = 8'h22;
            8'h94: r = 8'he7;  8'h95: r = 8'had;  8'h96: r = 8'h35;  8'h97: r = 8'h85;
            8'h98: r = 8'he2;  8'h99: r = 8'hf9;  8'h9a: r = 8'h37;  8'h9b: r = 8'he8;
            8'h9c: r = 8'h1c;  8'h9d: r = 8'h75;  8'h9e: r = 8'hdf;  8'h9f: r = 8'h6e;
            8'ha0: r = 8'h47;  8'ha1: r = 8'hf1;  8'ha2: r = 8'h1a;  8'ha3: r = 8'h71;
            8'ha4: r = 8'h1d;  8'ha5: r = 8'h29;  8'ha6: r = 8'hc5;  8'ha7: r = 8'h89;
            8'ha8: r = 8'h6f;  8'ha9: r = 8'hb7;  8'haa: r = 8'h62;  8'hab: r = 8'h0e;
            8'hac: r = 8'haa;  8'had: r = 8'h18;  8'hae: r = 8'hbe;  8'haf: r = 8'h1b;
            8'hb0: r = 8'hfc;  8'hb1: r = 8'h56;  8'hb2: r = 8'h3e;  8'hb3: r = 8'h4b;
            8'hb4: r = 8'hc6;  8'hb5: r = 8'hd2;  8'hb6: r = 8'h79;  8'hb7: r = 8'h20;
            8'hb8: r = 8'h9a;  8'hb9: r = 8'hdb;  8'hba: r = 8'hc0;  8'hbb: r = 8'hfe;
            8'hbc: r = 8'h78;  8'hbd: r = 8'hcd;  8'hbe: r = 8'h5a;  8'hbf: r = 8'hf4;
            8'hc0: r = 8'h1f;  8'hc1: r = 8'hdd;  8'hc2: r = 8'ha8;  8'hc3: r = 8'h33;
            8'hc4: r = 8'h88;  8'hc5: r = 8'h07;  8'hc6: r = 8'hc7;  8'hc7: r = 8'h31;
            8'hc8: r = 8'hb1;  8'hc9: r = 8'h12;  8'hca: r = 8'h10;  8'hcb: r = 8'h59;
            8'hcc: r = 8'h27;  8'hcd: r = 8'h80;  8'hce: r = 8'hec;  8'hcf: r = 8'h5f;
            8'hd0: r = 8'h60;  8'hd1: r = 8'h51;  8'hd2: r = 8'h7f;  8'hd3: r = 8'ha9;
            8'hd4: r = 8'h19;  8'hd5: r = 8'hb5;  8'hd6: r = 8'h4a;  8'hd7: r = 8'h0d;
            8'hd8: r = 8'h2d;  8'hd9: r = 8'he5;  8'hda: r = 8'h7a;  8'hdb: r = 8'h9f;
            8'hdc: r = 8'h93;  8'hdd: r = 8'hc9;  8'hde: r = 8'h9c;  8'hdf: r = 8'hef;
            8'he0: r = 8'ha0;  8'he1: r = 8'he0;  8'he2: r = 8'h3b;  8'he3: r = 8'h4d;
            8'he4: r = 8'hae;  8'he5: r = 8'h2a;  8'he6: r = 8'hf5;  8'he7: r = 8'hb0;
            8'he8: r = 8'hc8;  8'he9: r = 8'heb;  8'hea: r = 8'hbb;  8'heb: r = 8'h3c;
            8'hec: r = 8'h83;  8'hed: r = 8'h53;  8'hee: r = 8'h99;  8'hef: r = 8'h61;
            8'hf0: r = 8'h17;  8'hf1: r = 8'h2b;  8'hf2: r = 8'h04;  8'hf3: r = 8'h7e;
            8'hf4: r = 8'hba;  8'hf5: r = 8'h77;  8'hf6: r = 8'hd6;  8'hf7: r = 8'h26;
            8'hf8: r = 8'he1;  8'hf9: r = 8'h69;  8'hfa: r = 8'h14;  8'hfb: r = 8'h63;
            8'hfc: r = 8'h55;  8'hfd: r = 8'h21;  8'hfe: r = 8'h0c;  8'hff: r = 8'h7d;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

`ifdef INV_SUB_BYTES_FAST_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [127:0] inv_sub_state(input logic [127:0] s);
        logic [127:0] r;
        r = 128'h0;
        for (int i = 0; i < 16; i++) begin
            r[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
        end
        return r;
    endfunction
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
`endif

    state_t         r_state;
    state_t         w_state_nxt;
    logic [127:0]   r_out_state;
    logic           w_in_xfer;
    logic           w_out_xfer;

    assign w_in_xfer   = i_in_valid && o_in_ready;
    assign w_out_xfer  = o_out_valid && i_out_ready;
    assign o_out_state = r_out_state;

    // Handshake outputs decoded from FSM state; DONE forwards downstream readiness upstream
    always_comb begin
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_in_ready  = 1'b1;
                o_out_valid = 1'b0;
            end
            S_DONE: begin
                o_in_ready  = i_out_ready;
                o_out_valid = 1'b1;
            end
            default: begin
                o_in_ready  = 1'b0;
                o_out_valid = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef INV_SUB_BYTES_FAST_EN
    // Next-state: DONE re-enters itself when it hands off and accepts on the same edge
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_in_xfer) w_state_nxt = S_DONE;
                else           w_state_nxt = S_IDLE;
            end
            S_DONE: begin
                if (w_out_xfer && !w_in_xfer) w_state_nxt = S_IDLE;
                else                          w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Whole-state substitution captured on the input transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_state <= 128'h0;
        end else if (w_in_xfer) begin
            r_out_state <= inv_sub_state(i_in_state);
        end
    end
`else
    logic [127:0]   r_work;
    logic [1:0]     r_col;
    logic [6:0]     w_base;
    logic [31:0]    w_col_word;
    logic [31:0]    w_col_sub;

    // Column col occupies bits [127-32*col -: 32] in both the work and output registers
    assign w_base     = 7'd127 - {r_col, 5'd0};
    assign w_col_word = r_work[w_base -: 32];
    assign w_col_sub  = {inv_sbox(w_col_word[31:24]), inv_sbox(w_col_word[23:16]),
                         inv_sbox(w_col_word[15:8]),  inv_sbox(w_col_word[7:0])};

    // Next-state: a same-edge handoff in DONE goes straight back to RUN
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_in_xfer) w_state_nxt = S_RUN;
                else           w_state_nxt = S_IDLE;
            end
            S_RUN: begin
                if (r_col == 2'd3) w_state_nxt = S_DONE;
                else               w_state_nxt = S_RUN;
            end
            S_DONE: begin
                if (w_out_xfer) begin
                    if (w_in_xfer) w_state_nxt = S_RUN;
                    else           w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Work register capture and column-serial write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work      <= 128'h0;
            r_col       <= 2'd0;
            r_out_state <= 128'h0;
        end else if (w_in_xfer) begin
            r_work <= i_in_state;
            r_col  <= 2'd0;
        end else if (r_state == S_RUN) begin
            r_out_state[w_base -: 32] <= w_col_sub;
            r_col                     <= r_col + 2'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Directed bench for inv_sub_bytes_iter; expected data comes from a forward S-box table
// (feeding SubBytes(x) must return x) plus hand-computed vectors.
module tb_inv_sub_bytes_iter;

`ifdef INV_SUB_BYTES_FAST_EN
    localparam int EXTRA_EDGES = 0;
    localparam int GAP         = 1;
`else
    localparam int EXTRA_EDGES = 4;
    localparam int GAP         = 5;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_in_valid = 1'b0;
    logic         o_in_ready;
    logic [127:0] i_in_state = 128'h0;
    logic         o_out_valid;
    logic         i_out_ready = 1'b0;
    logic [127:0] o_out_state;

    int errors = 0;
    int checks = 0;
    logic [2047:0] fwd_tab;

    inv_sub_bytes_iter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_state  (i_in_state),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_state (o_out_state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fwd(input logic [7:0] x);
        return fwd_tab[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [127:0] fwd_block(input logic [127:0] b);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = fwd(b[127 - 8*i -: 8]);
        return r;
    endfunction

    // Present d and hold until accepted; returns #1 after the accepting edge.
    task automatic send(input logic [127:0] d);
        bit ok;
        ok = 1'b0;
        i_in_state = d;
        i_in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (o_in_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        #1;
        i_in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_accept: in_ready=%b, required acceptance within 50 cycles", o_in_ready);
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!o_out_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_in_valid = 1'b0;
        i_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 3;
        if (o_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", o_out_valid); end
        if (o_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", o_in_ready); end
        if (o_out_state !== 128'h0) begin errors++; $display("FAIL rst_out_state: got %h want 0", o_out_state); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks += 3;
        if (o_out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid: got %b want 0", o_out_valid); end
        if (o_in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b want 1", o_in_ready); end
        if (o_out_state !== 128'h0) begin errors++; $display("FAIL post_rst_out_state: got %h want 0", o_out_state); end
    endtask

    task automatic test_single();
        int lat;
        i_out_ready = 1'b1;
        send(128'h00637CFF_01000000_00000000_00000000);
        wait_valid(lat);
        checks += 2;
        if (lat !== EXTRA_EDGES) begin errors++; $display("FAIL single_latency: got %0d edges want %0d", lat, EXTRA_EDGES); end
        if (o_out_state !== 128'h5200017D_09525252_52525252_52525252) begin
            errors++;
            $display("FAIL single_data: got %h want 5200017d095252525252525252525252", o_out_state);
        end
        @(posedge clk);
        #1;
        checks += 2;
        if (o_out_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid: got %b want 0", o_out_valid); end
        if (o_in_ready !== 1'b1) begin errors++; $display("FAIL single_idle_ready: got %b want 1", o_in_ready); end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [127:0] b;
        b = 128'h0123456789ABCDEF_FEDCBA9876543210;
        i_out_ready = 1'b0;
        send(fwd_block(b));
        wait_valid(lat);
        i_in_valid = 1'b1;
        i_in_state = fwd_block(~b);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (o_out_valid !== 1'b1 || o_in_ready !== 1'b0 || o_out_state !== b) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b ready=%b data=%h want valid=1 ready=0 data=%h",
                         c, o_out_valid, o_in_ready, o_out_state, b);
            end
            @(posedge clk);
            #1;
        end
        i_in_valid = 1'b0;
        i_out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (o_out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: valid=%b want 0", o_out_valid); end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (o_out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_extra: valid=%b want 0", o_out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_q [4];
        int acc_cyc [4];
        int idx_in, idx_out, cyc;
        bit acc, oxf;
        exp_q[0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        exp_q[1] = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
        exp_q[2] = 128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C;
        exp_q[3] = 128'h3243F6A8_885A308D_313198A2_E0370734;
        idx_in = 0;
        idx_out = 0;
        cyc = 0;
        i_out_ready = 1'b1;
        i_in_state = fwd_block(exp_q[0]);
        i_in_valid = 1'b1;
        while (idx_out < 4 && cyc < 200) begin
            acc = o_in_ready && i_in_valid;
            oxf = o_out_valid && i_out_ready;
            if (oxf) begin
                checks++;
                if (o_out_state !== exp_q[idx_out]) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got %h want %h", idx_out, o_out_state, exp_q[idx_out]);
                end
                idx_out++;
            end
            if (acc) begin
                acc_cyc[idx_in] = cyc;
                idx_in++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                if (idx_in < 4) i_in_state = fwd_block(exp_q[idx_in]);
                else            i_in_valid = 1'b0;
            end
        end
        i_in_valid = 1'b0;
        checks++;
        if (idx_in !== 4 || idx_out !== 4) begin
            errors++;
            $display("FAIL b2b_count: accepted=%0d delivered=%0d want 4 and 4", idx_in, idx_out);
        end else begin
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (acc_cyc[k] - acc_cyc[k-1] !== GAP) begin
                    errors++;
                    $display("FAIL b2b_gap[%0d]: got %0d cycles want %0d", k, acc_cyc[k] - acc_cyc[k-1], GAP);
                end
            end
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (o_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_dup: valid=%b want 0", o_out_valid); end
    endtask

    task automatic test_mid_reset();
        int seen;
        i_out_ready = 1'b0;
        send(fwd_block(128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (o_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", o_out_valid); end
        if (o_in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", o_in_ready); end
        if (o_out_state !== 128'h0) begin errors++; $display("FAIL midrst_state: got %h want 0", o_out_state); end
        @(negedge clk);
        rst_n = 1'b1;
        i_out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (o_out_valid) seen++;
        end
        checks += 2;
        if (seen !== 0) begin errors++; $display("FAIL midrst_aborted: valid cycles=%0d want 0", seen); end
        if (o_out_state !== 128'h0) begin errors++; $display("FAIL midrst_state_after: got %h want 0", o_out_state); end
    endtask

    task automatic test_exhaustive();
        logic [127:0] e;
        int lat;
        i_out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 16; j++) e[127 - 8*j -: 8] = 8'(16*k + j);
            send(fwd_block(e));
            wait_valid(lat);
            checks++;
            if (lat !== EXTRA_EDGES || o_out_state !== e) begin
                errors++;
                $display("FAIL table_block[%0d]: got %h lat=%0d want %h lat=%0d", k, o_out_state, lat, e, EXTRA_EDGES);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        fwd_tab = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
                   128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
                   128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
                   128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
                   128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
                   128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
                   128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
                   128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_exhaustive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
